axi4l_apb_bridge_mslv: RTL

AXI4L_APB_BRIDGE_MSLV -- requirements
Module: axi4l_apb_bridge_mslv

---
 rtl/axi4l_apb_bridge_mslv.sv | 211 +++++++++++++++++++++
 1 files changed

// File: rtl/axi4l_apb_bridge_mslv.sv
// axi4l_apb_bridge_mslv: AXI4-Lite to multi-slave APB bridge, one transaction in flight.
// Define APB_TIMEOUT_EN to abort ACCESS phases that exceed TIMEOUT_CYC cycles with SLVERR.
module axi4l_apb_bridge_mslv #(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int NUM_SLV     = 4,
    parameter int SEL_LSB     = 12,
    parameter int TIMEOUT_CYC = 16
) (
    input  logic                      aclk,
    input  logic                      areset_n,
    input  logic [ADDR_W-1:0]         AWADDR,
    input  logic                      AWVALID,
    output logic                      AWREADY,
    input  logic [DATA_W-1:0]         WDATA,
    input  logic [DATA_W/8-1:0]       WSTRB,
    input  logic                      WVALID,
    output logic                      WREADY,
    output logic [1:0]                BRESP,
    output logic                      BVALID,
    input  logic                      BREADY,
    input  logic [ADDR_W-1:0]         ARADDR,
    input  logic                      ARVALID,
    output logic                      ARREADY,
    output logic [DATA_W-1:0]         RDATA,
    output logic [1:0]                RRESP,
    output logic                      RVALID,
    input  logic                      RREADY,
    output logic [ADDR_W-1:0]         PADDR,
    output logic [NUM_SLV-1:0]        PSEL,
    output logic                      PENABLE,
    output logic                      PWRITE,
    output logic [DATA_W-1:0]         PWDATA,
    output logic [DATA_W/8-1:0]       PSTRB,
    input  logic [NUM_SLV*DATA_W-1:0] PRDATA,
    input  logic [NUM_SLV-1:0]        PREADY,
    input  logic [NUM_SLV-1:0]        PSLVERR
);
    localparam int IW = NUM_SLV > 1 ? $clog2(NUM_SLV) : 1;
    localparam logic [4:0] NS = 5'(NUM_SLV);
`ifdef APB_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    logic [TW-1:0] tmo_q, tmo_d;
`endif
    typedef enum logic [2:0] {S_IDLE, S_SETUP, S_ACCESS, S_BRESP, S_RRESP} state_t;
    state_t state_q, state_d;
    logic wr_prio_q, wr_prio_d, awready_q, awready_d, arready_q, arready_d;
    logic bvalid_q, bvalid_d, rvalid_q, rvalid_d, penable_q, penable_d, pwrite_q, pwrite_d;
    logic [IW-1:0] idx_q, idx_d;
    logic [ADDR_W-1:0] paddr_q, paddr_d;
    logic [DATA_W-1:0] pwdata_q, pwdata_d, rdata_q, rdata_d, done_data;
    logic [DATA_W/8-1:0] pstrb_q, pstrb_d;
    logic [NUM_SLV-1:0] psel_q, psel_d;
    logic [1:0] resp_q, resp_d, done_resp;
    logic [ADDR_W-1:0] ax_addr;
    logic [4:0] fld;
    logic done;
    logic [DATA_W-1:0] prd [NUM_SLV];
    for (genvar g = 0; g < NUM_SLV; g++) begin : g_prd
        assign prd[g] = PRDATA[g*DATA_W +: DATA_W];
    end
    assign ax_addr = awready_q ? AWADDR : ARADDR;
    // the range check uses a 4-bit field (room for 16 slaves) so unmapped indices raise DECERR
    assign fld = {1'b0, ax_addr[SEL_LSB +: 4]};
    always_comb begin
        state_d   = state_q;
        wr_prio_d = wr_prio_q;
        awready_d = awready_q;
        arready_d = arready_q;
        bvalid_d  = bvalid_q;
        rvalid_d  = rvalid_q;
        penable_d = penable_q;
        pwrite_d  = pwrite_q;
        idx_d     = idx_q;
        paddr_d   = paddr_q;
        pwdata_d  = pwdata_q;
        pstrb_d   = pstrb_q;
        psel_d    = psel_q;
        resp_d    = resp_q;
        rdata_d   = rdata_q;
        done      = 1'b0;
        done_resp = 2'b00;
        done_data = '0;
`ifdef APB_TIMEOUT_EN
        tmo_d     = tmo_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (awready_q || arready_q) begin
                    awready_d = 1'b0;
                    arready_d = 1'b0;
                    pwrite_d  = awready_q;
                    paddr_d   = ax_addr;
                    pwdata_d  = awready_q ? WDATA : pwdata_q;
                    pstrb_d   = awready_q ? WSTRB : '0;
                    idx_d     = fld[IW-1:0];
                    if (fld >= NS) begin
                        state_d  = awready_q ? S_BRESP : S_RRESP;
                        bvalid_d = awready_q;
                        rvalid_d = arready_q;
                        resp_d   = 2'b11;
                        rdata_d  = awready_q ? rdata_q : '0;
                    end else begin
                        state_d = S_SETUP;
                        psel_d  = NUM_SLV'(1) << fld[IW-1:0];
                    end
                end else if (AWVALID && WVALID && (!ARVALID || wr_prio_q)) begin
                    awready_d = 1'b1;
                    wr_prio_d = ARVALID ? 1'b0 : wr_prio_q;
                end else if (ARVALID) begin
                    arready_d = 1'b1;
                    wr_prio_d = (AWVALID && WVALID) ? 1'b1 : wr_prio_q;
                end
            end
            S_SETUP: begin
                state_d   = S_ACCESS;
                penable_d = 1'b1;
`ifdef APB_TIMEOUT_EN
                tmo_d     = '0;
`endif
            end
            S_ACCESS: begin
                if (PREADY[idx_q]) begin
                    done      = 1'b1;
                    done_resp = PSLVERR[idx_q] ? 2'b10 : 2'b00;
                    done_data = prd[idx_q];
                end
`ifdef APB_TIMEOUT_EN
                else if (tmo_q == TW'(TIMEOUT_CYC - 1)) begin
                    done      = 1'b1;
                    done_resp = 2'b10;
                end else
                    tmo_d = tmo_q + 1'b1;
`endif
            end
            S_BRESP: begin
                bvalid_d = BREADY ? 1'b0 : bvalid_q;
                state_d  = BREADY ? S_IDLE : state_q;
            end
            S_RRESP: begin
                rvalid_d = RREADY ? 1'b0 : rvalid_q;
                state_d  = RREADY ? S_IDLE : state_q;
            end
            default: state_d = S_IDLE;
        endcase
        if (done) begin
            state_d   = pwrite_q ? S_BRESP : S_RRESP;
            psel_d    = '0;
            penable_d = 1'b0;
            bvalid_d  = pwrite_q;
            rvalid_d  = !pwrite_q;
            resp_d    = done_resp;
            rdata_d   = pwrite_q ? rdata_q : done_data;
        end
    end
    always_ff @(posedge aclk or negedge areset_n) begin
        if (!areset_n) begin
            state_q   <= S_IDLE;
            wr_prio_q <= 1'b1;
            awready_q <= 1'b0;
            arready_q <= 1'b0;
            bvalid_q  <= 1'b0;
            rvalid_q  <= 1'b0;
            penable_q <= 1'b0;
            pwrite_q  <= 1'b0;
            idx_q     <= '0;
            paddr_q   <= '0;
            pwdata_q  <= '0;
            pstrb_q   <= '0;
            psel_q    <= '0;
            resp_q    <= 2'b00;
            rdata_q   <= '0;
`ifdef APB_TIMEOUT_EN
            tmo_q     <= '0;
`endif
        end else begin
            state_q   <= state_d;
            wr_prio_q <= wr_prio_d;
            awready_q <= awready_d;
            arready_q <= arready_d;
            bvalid_q  <= bvalid_d;
            rvalid_q  <= rvalid_d;
            penable_q <= penable_d;
            pwrite_q  <= pwrite_d;
            idx_q     <= idx_d;
            paddr_q   <= paddr_d;
            pwdata_q  <= pwdata_d;
            pstrb_q   <= pstrb_d;
            psel_q    <= psel_d;
            resp_q    <= resp_d;
            rdata_q   <= rdata_d;
`ifdef APB_TIMEOUT_EN
            tmo_q     <= tmo_d;
`endif
        end
    end
    assign AWREADY = awready_q;
    assign WREADY  = awready_q;
    assign ARREADY = arready_q;
    assign BVALID  = bvalid_q;
    assign RVALID  = rvalid_q;
    assign BRESP   = resp_q;
    assign RRESP   = resp_q;
    assign RDATA   = rdata_q;
    assign PADDR   = paddr_q;
    assign PSEL    = psel_q;
    assign PENABLE = penable_q;
    assign PWRITE  = pwrite_q;
    assign PWDATA  = pwdata_q;
    assign PSTRB   = pstrb_q;
endmodule
